// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the adder-sharing arbiter: FSM state encoding and the
// requester-index width helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package adder_pkg;

    // Response slot state: empty or holding an unconsumed result.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int calc_idw(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter_if
// Request/response bundle between R requesters, the shared-adder arbiter and
// the result consumer.
// Signals:
//   req_valid [R]    per-requester valid
//   req_a/b   [R*N]  operands, requester i at [i*N +: N]
//   req_ready [R]    one-hot grant
//   rsp_valid        response slot full
//   rsp_id    [IDW]  requester that produced the result
//   rsp_sum   [N]    (a + b) mod 2^N
//   rsp_ready        consumer accepts the response
// Modports: master (requesters + consumer side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface adder_share_arbiter_if
    import adder_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 4
);
    localparam int IDW = calc_idw(R);

    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_sum;
    logic           rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );

endinterface

// File: rtl/Adder_Nbit.sv
// -----------------------------------------------------------------------------
// Adder_Nbit
// Plain unsigned N-bit adder; the carry-out is dropped so the result wraps
// modulo 2^N.
// Ports:
//   a_i, b_i [N]  operands
//   sum_o    [N]  (a_i + b_i) mod 2^N
// -----------------------------------------------------------------------------
module Adder_Nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans req starting at ptr and wrapping
// through R-1 back to 0; the first set bit wins. No state is kept here, so the
// owner of ptr decides how it advances.
// Ports:
//   req    [R]    request vector
//   ptr    [IDW]  index where the search starts
//   en            when low no grant is issued
//   gnt    [R]    one-hot grant (all zero when nothing granted)
//   gnt_id [IDW]  index of the granted requester (0 when nothing granted)
// -----------------------------------------------------------------------------
module rr_arbiter
    import adder_pkg::*;
#(
    parameter  int R   = 4,
    localparam int IDW = calc_idw(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [R-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic found;
    int   idx;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment; a path that skips one infers a latch.
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr) + k) % R;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
// Time-shares one N-bit adder between R requesters. A round-robin grant picks
// one valid requester per cycle; its operands go through the adder and the
// sum is registered into a single response slot tagged with the requester id.
// The slot holds under rsp_ready backpressure; with rsp_ready high a new
// result can replace the consumed one every cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    adder_share_arbiter_if.slave (requests in, grant + response out)
// -----------------------------------------------------------------------------
module adder_share_arbiter
    import adder_pkg::*;
#(
    parameter int N = 32,
    parameter int R = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    adder_share_arbiter_if.slave   bus
);

    localparam int IDW = calc_idw(R);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_sum_q, rsp_sum_d;

    logic           acc_en;
    logic           arb_en;
    logic           grant;
    logic [R-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   op_a, op_b, sum;

    // The slot can take a new result when empty or when it drains this cycle.
    // Reset gates the grant so no handshake completes while it is asserted.
    assign acc_en = (state_q == ST_IDLE) | bus.rsp_ready;
    assign arb_en = acc_en & ~reset;

    rr_arbiter #(.R(R)) u_arb (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign grant = |gnt;

    // Operand mux in front of the single shared adder.
    assign op_a = bus.req_a[int'(gnt_id)*N +: N];
    assign op_b = bus.req_b[int'(gnt_id)*N +: N];

    Adder_Nbit #(.N(N)) u_add (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (sum)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rsp_id_d  = rsp_id_q;
        rsp_sum_d = rsp_sum_q;

        case (state_q)
            ST_IDLE: if (grant)                  state_d = ST_FULL;
            ST_FULL: if (bus.rsp_ready && !grant) state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase

        // A grant always loads the slot (also overwriting a consumed result)
        // and moves the search start just past the winner.
        if (grant) begin
            ptr_d     = (gnt_id == IDW'(R - 1)) ? '0 : gnt_id + 1'b1;
            rsp_id_d  = gnt_id;
            rsp_sum_d = sum;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            rsp_id_q  <= '0;
            rsp_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rsp_id_q  <= rsp_id_d;
            rsp_sum_q <= rsp_sum_d;
        end
    end

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = (state_q == ST_FULL);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;

endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that time-shares a single N-bit adder between R independent requesters in the processor datapath, so one physical `Adder_Nbit` serves multiple address/increment clients. Requests use a valid/ready handshake. Operands from the winning requester pass through the adder, and the sum is registered into a single response slot tagged with the requester ID. The response slot is held under `rsp_ready` backpressure, and with `rsp_ready` held high the block sustains one operation per cycle.

## Interface
- `N`, 32, operand/sum width in bits
- `R`, 4, number of requesters (≥2); `IDW = $clog2(R)`
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input R: per-requester request valid.
- `req_a` input R*N: operand A; requester i occupies bits [i*N +: N].
- `req_b` input R*N: operand B, same packing.
- `req_ready` output R: one-hot grant. The handshake completes where `req_valid[i] & req_ready[i]`.
- `rsp_valid` output 1: response slot holds a result.
- `rsp_id` output IDW: index of the requester that produced the result.
- `rsp_sum` output N: (a + b) mod 2^N.
- `rsp_ready` input 1: consumer accepts the response this cycle.

## Operation
- FSM states: `IDLE` (slot empty) and `FULL` (slot holds an unconsumed result).
- Accept-enable: `acc_en = (state == IDLE) | rsp_ready`.
- `req_ready`:
  - When `acc_en` and any `req_valid`, `req_ready` is the combinational one-hot pick from `req_valid`.
  - Otherwise `req_ready` is 0.
  - `req_ready` never has more than one bit set.
- Round-robin pick:
  - Search starts at pointer `ptr` and proceeds `ptr, ptr+1, …, R-1, 0, …`. The first set `req_valid` bit wins.
  - On a grant to g, `ptr <= (g+1) mod R`. The wrap goes from R-1 to 0.
  - `ptr` does not change when there is no grant.
- Datapath: a mux selects the granted operands into the adder. On a grant edge, `rsp_sum` <= adder output, `rsp_id` <= g, and the state becomes `FULL`.
- Transitions:
  - `IDLE` with a grant → `FULL`.
  - `IDLE` with no request → `IDLE`.
  - `FULL` with `rsp_ready` and a grant → `FULL`, slot overwritten with the new result (back-to-back).
  - `FULL` with `rsp_ready` and no grant → `IDLE`.
  - `FULL` with `!rsp_ready` → `FULL`. `rsp_sum` and `rsp_id` stay stable and all `req_ready` are 0.
- Arithmetic: unsigned modulo 2^N. Carry-out is discarded and there is no overflow flag.
- Requesters may drop `req_valid` before being granted. The arbiter re-evaluates every cycle and keeps no request state.
- `rsp_valid = (state == FULL)`.

## Timing
- Reset values: state `IDLE`, `ptr` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_sum` 0, `req_ready` 0.
- Reset asserted in `FULL` drops `rsp_valid` at the next edge, and the pending result is discarded.
- While `reset` is high, `req_ready` is forced to 0.
- Latency: the handshake is at edge k, and `rsp_valid`/`rsp_sum` are visible after edge k (one cycle).
- Throughput: 1 op/cycle while `rsp_ready` is held high. Each requester is granted at most once every R cycles under full contention.
- Fairness: with all R requesters continuously valid, grants rotate in strict order `ptr, ptr+1, …`. No requester waits more than R-1 grants.
- `req_ready` depends combinationally on `req_valid`, `state`, `ptr` and `rsp_ready`. It does not depend on the operands. `rsp_*` outputs are registered.

## Structure
- Shared package (`adder_pkg`): `IDW` function/constant, and the FSM state encoding `ST_IDLE=1'b0` and `ST_FULL=1'b1`.
- Sub-module `rr_arbiter #(R)`:
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and index `gnt_id`.
  - Purely combinational, and reusable.
- The adder is a single `Adder_Nbit #(N)` instance. The top-level holds the FSM, `ptr`, the operand mux and the response registers.

## Test plan
- **Reset/idle:** hold `reset` 2 cycles with all `req_valid` = 1 → all outputs 0 during reset. The first grant after release goes to req0.
- **Single op and wrap:** N=8, req2 sends a=0xFF, b=0x02 with `rsp_ready`=1 → `req_ready`=4'b0100 for one cycle. Next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0x01.
- **Round-robin:** all 4 requesters valid continuously with `rsp_ready`=1 → grants 0,1,2,3,0,1 on consecutive cycles. `rsp_id` follows the same order one cycle later.
- **Backpressure:** slot holds id1 sum 0x30 with `rsp_ready`=0 for 3 cycles → `rsp_sum`/`rsp_id` stable and `req_ready`=0. When `rsp_ready` rises, a new grant occurs in the same cycle.
- **Pointer skip:** `ptr`=2 with only req0 and req1 valid → req0 granted and `ptr` becomes 1. The next grant goes to req1.
- **Reset mid-op:** assert `reset` while `FULL` with `rsp_ready`=0 → `rsp_valid`=0 and `ptr`=0 at the next edge. No stale response appears after release.
